// File: rtl/approx_err_monitor.sv
// approx_err_monitor: windowed error statistics (sum/max/count of ED) for an 8x8 approximate multiplier.
// Define APPROX_ERR_BIAS_EN to build the signed bias accumulator; otherwise bias_sum is tied to 0.
module approx_err_monitor #(
  parameter int LOG2_N = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 a,
  input  logic [7:0]                 b,
  input  logic [15:0]                y_approx,
  output logic [15+LOG2_N:0]         sum_ed,
  output logic [15:0]                max_ed,
  output logic [LOG2_N:0]            err_cnt,
  output logic signed [16+LOG2_N:0]  bias_sum,
  output logic                       res_valid,
  output logic                       done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [LOG2_N:0] LAST = {1'b0, {LOG2_N{1'b1}}};
  state_t state_q, state_d;
  logic [LOG2_N:0] cnt_q, cnt_d;
  logic [15:0] exact, ed;
  logic signed [16:0] err;
  logic [15:0] ed_q, max_q, max_d;
  logic nz_q, v1_q, done_q, accept, clr;
  logic [15+LOG2_N:0] sum_q, sum_d;
  logic [LOG2_N:0] errc_q, errc_d;
  assign exact = {8'd0, a} * {8'd0, b};
  assign err = $signed({1'b0, y_approx}) - $signed({1'b0, exact});
  assign ed = err[16] ? 16'(-err) : err[15:0];
  assign in_ready = state_q == RUN;
  assign accept = in_valid && in_ready;
  assign res_valid = state_q == DONE;
  assign done = done_q;
  assign sum_ed = sum_q;
  assign max_ed = max_q;
  assign err_cnt = errc_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    clr = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        clr = 1'b1;
      end
      RUN: if (accept) begin
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == LAST ? DRAIN : RUN;
      end
      DRAIN: state_d = DONE;
      DONE: if (start) begin
        state_d = RUN;
        clr = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    cnt_d = clr ? '0 : cnt_d;
  end
  // stage 2 folds the sample registered by stage 1 on the previous edge
  always_comb begin
    sum_d = clr ? '0 : v1_q ? sum_q + (16+LOG2_N)'(ed_q) : sum_q;
    max_d = clr ? '0 : (v1_q && ed_q > max_q) ? ed_q : max_q;
    errc_d = clr ? '0 : (v1_q && nz_q) ? errc_q + 1'b1 : errc_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ed_q <= '0;
      nz_q <= 1'b0;
      v1_q <= 1'b0;
      done_q <= 1'b0;
      sum_q <= '0;
      max_q <= '0;
      errc_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      v1_q <= accept;
      done_q <= state_q == DRAIN;
      sum_q <= sum_d;
      max_q <= max_d;
      errc_q <= errc_d;
      if (accept) begin
        ed_q <= ed;
        nz_q <= ed != 16'd0;
      end
    end
  end
`ifdef APPROX_ERR_BIAS_EN
  logic signed [16:0] err_q;
  logic signed [16+LOG2_N:0] bias_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
      bias_q <= '0;
    end else begin
      if (accept) err_q <= err;
      bias_q <= clr ? '0 : v1_q ? bias_q + {{LOG2_N{err_q[16]}}, err_q} : bias_q;
    end
  end
  assign bias_sum = bias_q;
`else
  assign bias_sum = '0;
`endif
endmodule

// File: tb/tb_approx_err_monitor.sv
// tb_approx_err_monitor: directed windows with a result scoreboard popped on each done pulse.
module tb_approx_err_monitor;
  logic clk = 0, rst = 1, start = 0, in_valid = 0;
  logic [7:0] a = 0, b = 0;
  logic [15:0] y = 0;
  logic in_ready, res_valid, done;
  logic [17:0] sum_ed;
  logic [15:0] max_ed;
  logic [2:0] err_cnt;
  logic signed [18:0] bias_sum;
  approx_err_monitor #(.LOG2_N(2)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .y_approx(y), .sum_ed(sum_ed), .max_ed(max_ed), .err_cnt(err_cnt),
    .bias_sum(bias_sum), .res_valid(res_valid), .done(done)
  );
  always #5 clk = ~clk;
  typedef struct {longint s; longint m; longint c; longint bs;} exp_t;
  exp_t q[$];
  exp_t e_m;
  int n_cmp = 0, n_fail = 0;
  logic prev_done = 0;
  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask
  task automatic push(input longint s, input longint m, input longint c, input longint bs);
    exp_t e;
    e.s = s;
    e.m = m;
    e.c = c;
`ifdef APPROX_ERR_BIAS_EN
    e.bs = bs;
`else
    e.bs = 0;
`endif
    q.push_back(e);
  endtask
  always @(negedge clk) begin
    if (done) begin
      chk("done_width", prev_done, 0);
      chk("sb_has_entry", q.size() > 0, 1);
      if (q.size() > 0) begin
        e_m = q.pop_front();
        chk("sum_ed", sum_ed, e_m.s);
        chk("max_ed", max_ed, e_m.m);
        chk("err_cnt", err_cnt, e_m.c);
        chk("bias_sum", bias_sum, e_m.bs);
        chk("res_valid", res_valid, 1);
      end
    end
    prev_done = done;
  end
  task automatic start_win();
    @(negedge clk);
    start = 1; in_valid = 1; a = 255; b = 255; y = 0;
    @(posedge clk); #1;
    start = 0; in_valid = 0;
  endtask
  task automatic send(input logic [7:0] aa, input logic [7:0] bb, input logic [15:0] yy);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready", in_ready, 1);
    a = aa; b = bb; y = yy; in_valid = 1;
    @(posedge clk); #1;
  endtask
  task automatic bubble();
    @(negedge clk);
    in_valid = 0; a = 255; b = 255; y = 0;
    @(posedge clk); #1;
  endtask
  task automatic end_win();
    @(negedge clk);
    in_valid = 0;
    chk("drain_in_ready", in_ready, 0);
    chk("drain_done", done, 0);
    @(negedge clk);
    chk("done_latency", done, 1);
    chk("done_res_valid", res_valid, 1);
  endtask
  task automatic ed_set();
    send(15, 15, 222);
    send(10, 10, 100);
    send(20, 20, 390);
    send(7, 7, 48);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum_ed, 0);
    chk("rst_max", max_ed, 0);
    chk("rst_cnt", err_cnt, 0);
    chk("rst_bias", bias_sum, 0);
    rst = 0;
    @(negedge clk);
    in_valid = 1; a = 9; b = 9; y = 0;
    @(posedge clk); #1;
    chk("idle_no_ready", in_ready, 0);
    in_valid = 0;
    push(0, 0, 0, 0);
    start_win();
    send(3, 5, 15); send(200, 100, 20000); send(0, 0, 0); send(255, 255, 65025);
    end_win();
    push(14, 10, 3, -14);
    start_win();
    @(negedge clk);
    chk("restart_res_valid", res_valid, 0);
    ed_set();
    end_win();
    push(260100, 65025, 4, -260100);
    start_win();
    repeat (4) send(255, 255, 0);
    end_win();
    push(55, 50, 3, 53);
    start_win();
    start = 1;
    send(2, 3, 10); bubble(); bubble();
    send(4, 4, 16); bubble();
    send(1, 1, 0);
    start = 0;
    bubble(); bubble();
    send(100, 2, 250);
    end_win();
    start_win();
    send(255, 255, 0); send(255, 255, 0);
    @(negedge clk);
    in_valid = 0; rst = 1;
    #1;
    chk("midrst_sum", sum_ed, 0);
    chk("midrst_max", max_ed, 0);
    chk("midrst_cnt", err_cnt, 0);
    chk("midrst_bias", bias_sum, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_done", done, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    in_valid = 1; a = 255; b = 255; y = 0;
    chk("post_rst_idle", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 0;
    push(14, 10, 3, -14);
    start_win();
    ed_set();
    end_win();
    repeat (3) @(negedge clk);
    chk("sb_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
